// File: rtl/inner_product_mac.sv
// Sequential dot-product unit: one multiply-accumulate per clock,
// with signed/unsigned operands, saturate/wrap output and chaining.
module inner_product_mac #(
  parameter int number_of_elements = 4,
  parameter int WORD_WIDTH         = 32,
  parameter int OUT_WIDTH          = 32,
  parameter bit SIGNED             = 1'b1,
  parameter bit SATURATE           = 1'b1
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic [WORD_WIDTH*number_of_elements-1:0] row,
  input  logic [WORD_WIDTH*number_of_elements-1:0] column,
  input  logic                                     row_i_stb,
  input  logic                                     column_i_stb,
  input  logic                                     acc_en,
  output logic                                     row_i_ack,
  output logic                                     column_i_ack,
  output logic [OUT_WIDTH-1:0]                     out,
  output logic                                     out_o_stb,
  input  logic                                     out_o_ack,
  output logic                                     overflow
);

  localparam int N    = number_of_elements;
  localparam int W    = WORD_WIDTH;
  localparam int O    = OUT_WIDTH;
  localparam int AW_P = 2*W + $clog2(N) + 1;
  localparam int AW   = (AW_P > O+1) ? AW_P : O+1;
  localparam int XW   = (N > 1) ? $clog2(N) : 1;

  localparam logic [XW-1:0] LAST = XW'(N-1);

  typedef enum logic [1:0] {
    IDLE, MAC, FINAL, OUTPUT
  } state_t;

  state_t          state;
  state_t          state_nx;
  logic [XW-1:0]   idx;
  logic [W*N-1:0]  row_q;
  logic [W*N-1:0]  col_q;
  logic [AW-1:0]   acc;
  logic [AW-1:0]   acc_init;
  logic [AW-1:0]   prod;
  logic [O-1:0]    last;
  logic [W-1:0]    a;
  logic [W-1:0]    b;
  logic [2*W-1:0]  p_raw;
  logic            fits;
  logic [O-1:0]    conv;
  logic            capture;

  assign capture = (state == IDLE)
                 & row_i_stb
                 & column_i_stb;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next-state decode
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (capture)      state_nx = MAC;
      MAC:     if (idx == LAST)  state_nx = FINAL;
      FINAL:                     state_nx = OUTPUT;
      OUTPUT:  if (out_o_ack)    state_nx = IDLE;
      default:                   state_nx = IDLE;
    endcase
  end

  // Select the current element pair from the latched vectors
  always_comb begin
    a = '0;
    b = '0;
    for (int i = 0; i < N; i++) begin
      if (idx == XW'(i)) begin
        a = row_q[W*i +: W];
        b = col_q[W*i +: W];
      end
    end
  end

  // Product and accumulator seed, extended per operand mode
  always_comb begin
    if (SIGNED) begin
      p_raw = $signed({{W{a[W-1]}}, a})
            * $signed({{W{b[W-1]}}, b});
      prod  = {{(AW-2*W){p_raw[2*W-1]}}, p_raw};
    end else begin
      p_raw = {{W{1'b0}}, a} * {{W{1'b0}}, b};
      prod  = {{(AW-2*W){1'b0}}, p_raw};
    end
    acc_init = '0;
    if (acc_en) begin
      if (SIGNED)
        acc_init = {{(AW-O){last[O-1]}}, last};
      else
        acc_init = {{(AW-O){1'b0}}, last};
    end
  end

  // Narrow the accumulator to the output width
  always_comb begin
    if (SIGNED)
      fits = acc[AW-1:O-1] == {(AW-O+1){acc[AW-1]}};
    else
      fits = acc[AW-1:O] == '0;
    conv = acc[O-1:0];
    if (!fits && SATURATE) begin
      if (SIGNED)
        conv = {acc[AW-1], {(O-1){~acc[AW-1]}}};
      else
        conv = {O{1'b1}};
    end
  end

  // Datapath, handshakes and result registers
  always_ff @(posedge clk) begin
    if (rst) begin
      idx          <= '0;
      acc          <= '0;
      last         <= '0;
      row_q        <= '0;
      col_q        <= '0;
      out          <= '0;
      out_o_stb    <= 1'b0;
      overflow     <= 1'b0;
      row_i_ack    <= 1'b0;
      column_i_ack <= 1'b0;
    end else begin
      row_i_ack    <= 1'b0;
      column_i_ack <= 1'b0;
      unique case (state)
        IDLE: begin
          if (capture) begin
            row_q        <= row;
            col_q        <= column;
            idx          <= '0;
            acc          <= acc_init;
            row_i_ack    <= 1'b1;
            column_i_ack <= 1'b1;
          end
        end
        MAC: begin
          acc <= acc + prod;
          idx <= idx + XW'(1);
        end
        FINAL: begin
          out       <= conv;
          last      <= conv;
          overflow  <= ~fits;
          out_o_stb <= 1'b1;
        end
        OUTPUT: begin
          if (out_o_ack) begin
            out_o_stb <= 1'b0;
            overflow  <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_inner_product_mac.sv
// Directed bench: three variants (signed/sat, signed/wrap,
// unsigned/sat) driven in lockstep from shared inputs.
module tb_inner_product_mac;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] row;
  logic [31:0] column;
  logic        row_i_stb;
  logic        column_i_stb;
  logic        acc_en;
  logic        out_o_ack;

  logic        ra [3];
  logic        ca [3];
  logic [15:0] o  [3];
  logic        st [3];
  logic        ov [3];

  logic [5:0]  acks;
  logic [2:0]  sts;
  logic [2:0]  ovs;
  logic [47:0] outs;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  assign acks = {ra[0], ca[0], ra[1], ca[1], ra[2], ca[2]};
  assign sts  = {st[0], st[1], st[2]};
  assign ovs  = {ov[0], ov[1], ov[2]};
  assign outs = {o[0], o[1], o[2]};

  inner_product_mac #(
    .number_of_elements(4), .WORD_WIDTH(8),
    .OUT_WIDTH(16), .SIGNED(1'b1), .SATURATE(1'b1)
  ) u_ss (
    .clk(clk), .rst(rst), .row(row), .column(column),
    .row_i_stb(row_i_stb), .column_i_stb(column_i_stb),
    .acc_en(acc_en), .row_i_ack(ra[0]),
    .column_i_ack(ca[0]), .out(o[0]),
    .out_o_stb(st[0]), .out_o_ack(out_o_ack),
    .overflow(ov[0])
  );

  inner_product_mac #(
    .number_of_elements(4), .WORD_WIDTH(8),
    .OUT_WIDTH(16), .SIGNED(1'b1), .SATURATE(1'b0)
  ) u_sw (
    .clk(clk), .rst(rst), .row(row), .column(column),
    .row_i_stb(row_i_stb), .column_i_stb(column_i_stb),
    .acc_en(acc_en), .row_i_ack(ra[1]),
    .column_i_ack(ca[1]), .out(o[1]),
    .out_o_stb(st[1]), .out_o_ack(out_o_ack),
    .overflow(ov[1])
  );

  inner_product_mac #(
    .number_of_elements(4), .WORD_WIDTH(8),
    .OUT_WIDTH(16), .SIGNED(1'b0), .SATURATE(1'b1)
  ) u_us (
    .clk(clk), .rst(rst), .row(row), .column(column),
    .row_i_stb(row_i_stb), .column_i_stb(column_i_stb),
    .acc_en(acc_en), .row_i_ack(ra[2]),
    .column_i_ack(ca[2]), .out(o[2]),
    .out_o_stb(st[2]), .out_o_ack(out_o_ack),
    .overflow(ov[2])
  );

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic capture(input logic [31:0] rv,
                         input logic [31:0] cv,
                         input logic        ae);
    row          = rv;
    column       = cv;
    acc_en       = ae;
    row_i_stb    = 1'b1;
    column_i_stb = 1'b1;
    step();
    row_i_stb    = 1'b0;
    column_i_stb = 1'b0;
    check("ack_pulse", acks, 64'h3f);
  endtask

  task automatic wait_result(input logic [15:0] e0,
                             input logic [15:0] e1,
                             input logic [15:0] e2,
                             input logic [2:0]  eov);
    for (int k = 1; k <= 5; k++) begin
      step();
      if (k == 1) check("ack_drop", acks, 64'h0);
      if (k < 5)  check("stb_low", sts, 64'h0);
      else        check("stb_rise", sts, 64'h7);
    end
    check("out", outs, {16'h0, e0, e1, e2});
    check("ovf", ovs, {61'h0, eov});
  endtask

  task automatic accept(input logic [47:0] eo);
    out_o_ack = 1'b1;
    step();
    out_o_ack = 1'b0;
    check("stb_drop", sts, 64'h0);
    check("ovf_clr", ovs, 64'h0);
    check("out_keep", outs, {16'h0, eo});
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation bound expired");
    $fatal(1);
  end

  initial begin
    rst          = 1'b1;
    row          = '0;
    column       = '0;
    row_i_stb    = 1'b0;
    column_i_stb = 1'b0;
    acc_en       = 1'b0;
    out_o_ack    = 1'b0;
    repeat (2) step();
    rst = 1'b0;
    check("rst_out", outs, 64'h0);
    check("rst_stb", sts, 64'h0);
    check("rst_ovf", ovs, 64'h0);
    check("rst_ack", acks, 64'h0);

    out_o_ack = 1'b1;
    step();
    out_o_ack = 1'b0;
    check("idle_oack", sts, 64'h0);

    // [1,2,3,4].[5,6,7,8] = 70
    capture(32'h04030201, 32'h08070605, 1'b0);
    wait_result(16'd70, 16'd70, 16'd70, 3'b000);
    accept({16'd70, 16'd70, 16'd70});

    // chained: 70 + 4 = 74
    capture(32'h01010101, 32'h01010101, 1'b1);
    wait_result(16'd74, 16'd74, 16'd74, 3'b000);
    accept({16'd74, 16'd74, 16'd74});

    capture(32'h01010101, 32'h01010101, 1'b0);
    wait_result(16'd4, 16'd4, 16'd4, 3'b000);
    accept({16'd4, 16'd4, 16'd4});

    // -128 squared x4 = 65536 (unsigned: 128^2 x4 too)
    capture(32'h80808080, 32'h80808080, 1'b0);
    wait_result(16'h7fff, 16'h0000, 16'hffff, 3'b111);
    accept({16'h7fff, 16'h0000, 16'hffff});

    // chain from clamped/wrapped results
    capture(32'h01010101, 32'h01010101, 1'b1);
    wait_result(16'h7fff, 16'h0004, 16'hffff, 3'b101);
    accept({16'h7fff, 16'h0004, 16'hffff});

    // all 255: signed -1*-1*4 = 4; unsigned 260100
    capture(32'hffffffff, 32'hffffffff, 1'b0);
    wait_result(16'h0004, 16'h0004, 16'hffff, 3'b001);
    accept({16'h0004, 16'h0004, 16'hffff});

    // [-3,2,0,0].[5,5,0,0]: signed -5, unsigned 1275
    capture(32'h000002fd, 32'h00000505, 1'b0);
    wait_result(16'hfffb, 16'hfffb, 16'h04fb, 3'b000);
    accept({16'hfffb, 16'hfffb, 16'h04fb});

    // chain: sign- vs zero-extension of previous result
    capture(32'h01010101, 32'h01010101, 1'b1);
    wait_result(16'hffff, 16'hffff, 16'h04ff, 3'b000);
    accept({16'hffff, 16'hffff, 16'h04ff});

    // one-sided strobes never capture
    row_i_stb = 1'b1;
    repeat (3) begin
      step();
      check("row_only", {acks, sts}, 64'h0);
    end
    row_i_stb    = 1'b0;
    column_i_stb = 1'b1;
    repeat (3) begin
      step();
      check("col_only", {acks, sts}, 64'h0);
    end
    column_i_stb = 1'b0;

    // backpressure with pending input strobes
    capture(32'h01010101, 32'h01010101, 1'b0);
    wait_result(16'd4, 16'd4, 16'd4, 3'b000);
    row          = 32'h04030201;
    column       = 32'h08070605;
    acc_en       = 1'b0;
    row_i_stb    = 1'b1;
    column_i_stb = 1'b1;
    repeat (10) begin
      step();
      check("bp_out", outs, {16'h0, 16'd4, 16'd4, 16'd4});
      check("bp_stb", sts, 64'h7);
      check("bp_noack", acks, 64'h0);
    end
    out_o_ack = 1'b1;
    step();
    out_o_ack = 1'b0;
    check("bp_drop", sts, 64'h0);
    check("bp_noack2", acks, 64'h0);
    step();
    row_i_stb    = 1'b0;
    column_i_stb = 1'b0;
    check("bp_capture", acks, 64'h3f);
    wait_result(16'd70, 16'd70, 16'd70, 3'b000);
    accept({16'd70, 16'd70, 16'd70});

    // reset two edges after capture
    capture(32'h01010101, 32'h01010101, 1'b1);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("mid_rst_out", outs, 64'h0);
    check("mid_rst_stb", {sts, ovs, acks}, 64'h0);
    repeat (6) begin
      step();
      check("rst_quiet", {sts, acks}, 64'h0);
    end
    capture(32'h04030201, 32'h08070605, 1'b1);
    wait_result(16'd70, 16'd70, 16'd70, 3'b000);
    accept({16'd70, 16'd70, 16'd70});

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/inner_product_mac.md
Name: inner_product_mac

Overview:
- Parametrised successor to the single-shot matrix-row inner-product unit.
- Computes the dot product of a row vector and a column vector of integers with one sequential multiply-accumulate per clock.
- Adds signed/unsigned mode, configurable output width with saturate or wrap, and chained accumulation so long dot products can be split across several transactions.
- Sits between the matrix operand fetch logic and the result collector; uses stb/ack handshakes on both sides.

Parameters:
- number_of_elements, 4: vector length N (N >= 1).
- WORD_WIDTH, 32: width W of each element.
- OUT_WIDTH, 32: width of the result port.
- SIGNED, 1: 1 = two's-complement operands and result; 0 = unsigned.
- SATURATE, 1: 1 = clamp the result to the OUT_WIDTH range; 0 = keep the low OUT_WIDTH bits.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  reset; synchronous, active-high.
- row  in  W*N  flattened row vector; element i occupies bits [W*(i+1)-1 : W*i].
- column  in  W*N  flattened column vector; same element packing as row.
- row_i_stb  in  1  row vector valid.
- column_i_stb  in  1  column vector valid.
- acc_en  in  1  sampled at capture; 1 = start from the previous result.
- row_i_ack  out  1  one-cycle pulse: row vector consumed.
- column_i_ack  out  1  one-cycle pulse: column vector consumed.
- out  out  OUT_WIDTH  result; held stable while out_o_stb is high.
- out_o_stb  out  1  result valid.
- out_o_ack  in  1  consumer accepts the result.
- overflow  out  1  result was clamped or wrapped; valid with out_o_stb.

Behaviour:
- Reset (rst high at an edge):
  - state = IDLE; index = 0; accumulator = 0; last-result register = 0.
  - out = 0, out_o_stb = 0, overflow = 0, row_i_ack = 0, column_i_ack = 0.
  - Overrides any state, including mid-MAC and mid-OUTPUT. An in-flight transaction is abandoned and no stb is emitted for it.
- States: IDLE, MAC, FINAL, OUTPUT.
- IDLE:
  - If row_i_stb & column_i_stb are both high at an edge (E0), latch row, column and acc_en, then go to MAC with index = 0.
  - Accumulator init: acc_en = 1 gives the last-result register, sign-extended (SIGNED=1) or zero-extended (SIGNED=0); acc_en = 0 gives 0.
  - row_i_ack and column_i_ack are both high for exactly the one cycle after E0.
  - If only one stb is high: no capture and no ack.
- MAC:
  - At edges E1..EN: accumulator += row[index] * column[index]; index increments.
  - Product is 2W bits; signed or unsigned per SIGNED.
  - Accumulator width is max(2W + clog2(N) + 1, OUT_WIDTH + 1), so it never overflows internally.
  - After index N-1 go to FINAL.
- FINAL (edge EN+1): convert the accumulator to OUT_WIDTH, load out and the last-result register, set out_o_stb = 1, go to OUTPUT.
  - SATURATE=1: clamp to [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1] when signed, or [0, 2^OUT_WIDTH-1] when unsigned. overflow = 1 iff a clamp occurred.
  - SATURATE=0: take the low OUT_WIDTH bits. overflow = 1 iff the value changed.
  - The last-result register holds the converted (clamped or wrapped) value.
- Latency: out_o_stb rises N+1 cycles after the capture edge.
- OUTPUT:
  - out, overflow and out_o_stb are held until out_o_ack is sampled high.
  - At that edge: out_o_stb = 0, overflow = 0, go to IDLE. out keeps its value.
  - No new capture in that same cycle; earliest next capture is the following edge.
- Input stb is ignored, with no ack, in MAC, FINAL and OUTPUT; no input is lost or double-consumed.
- out_o_ack while out_o_stb is low has no effect.
- N = 1 is legal: a single MAC edge, latency 2.

Test Plan:
- Products: N=4, W=8, OUT=16, SIGNED=1, SATURATE=1; row=[1,2,3,4], column=[5,6,7,8] -> ack pulse for 1 cycle after capture; out_o_stb at capture+5; out=70, overflow=0.
- Clamp and wrap: all elements -128 in both vectors -> sum 65536. SATURATE=1 gives out=32767, overflow=1; SATURATE=0 gives out=0, overflow=1.
- Chaining: after the 70 result, row=[1,1,1,1], column=[1,1,1,1], acc_en=1 -> out=74. Repeat with acc_en=0 -> out=4.
- Backpressure: hold out_o_ack low for 10 cycles while driving new stb -> out and out_o_stb stable, no input ack. Raise out_o_ack -> stb drops next cycle, new capture the edge after.
- Mid-operation reset: rst at capture+2 -> all outputs 0, no out_o_stb. Next transaction with acc_en=1 and [1,2,3,4]·[5,6,7,8] -> out=70.
- Unsigned mode: SIGNED=0, W=8, OUT=16; all elements 255 -> 260100 clamps to out=65535, overflow=1. One-sided stb (row only) -> no ack, stays IDLE.
